// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } sched_state_t;

  // Architectural zero register; never a forwarding or hazard source.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: forwarding selects, load-use stalls, branch flushes,
// memory-wait freeze with watchdog, and stall/flush performance counters.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RS1D,
  input  logic [REG_W-1:0] RS2D,
  input  logic [REG_W-1:0] RS1E,
  input  logic [REG_W-1:0] RS2E,
  input  logic [REG_W-1:0] RDE,
  input  logic             RegWriteE,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [REG_W-1:0]  RZ = REG_W'(REG_ZERO);

  sched_state_t      state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              lw_hz;
  logic              freeze;
  logic              branch_flush;

  function automatic fwd_sel_t fwd_sel(input logic [REG_W-1:0] rs);
    if (RegWriteM && (RdM != RZ) && (RdM == rs)) begin
      return FWD_M;
    end else if (RegWriteW && (RdW != RZ) && (RdW == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  assign lw_hz = ResultSrcE & RegWriteE & (RDE != RZ) & ((RDE == RS1D) | (RDE == RS2D));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          // Watchdog: give up on the access and let the pipeline move again.
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    ForwardAE    = FWD_RF;
    ForwardBE    = FWD_RF;
    freeze       = 1'b0;
    branch_flush = 1'b0;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushW       = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_sel(RS1E);
      ForwardBE = fwd_sel(RS2E);
      unique case (state_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            freeze = 1'b1;
          end else if (PCSrcE) begin
            branch_flush = 1'b1;
            FlushD       = 1'b1;
            FlushE       = 1'b1;
          end else if (lw_hz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        MEM_WAIT: begin
          freeze = !mem_ready && (wait_cnt_q != TIMEOUT_LAST);
        end
      endcase
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (StallF),
    .clr  (clr_cnt),
    .count(stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (branch_flush),
    .clr  (clr_cnt),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: per-cycle behavioural model plus literal spot checks.
module tb_hazard_scheduler;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 10;  // narrow counters so saturation is reachable quickly
  localparam int TIMEOUT = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [REG_W-1:0] RS1D, RS2D, RS1E, RS2E, RDE, RdM, RdW;
  logic RegWriteE, ResultSrcE, PCSrcE, RegWriteM, RegWriteW, mem_req, mem_ready, clr_cnt;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_scheduler #(
    .REG_W      (REG_W),
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RS1D      (RS1D),
    .RS2D      (RS2D),
    .RS1E      (RS1E),
    .RS2E      (RS2E),
    .RDE       (RDE),
    .RegWriteE (RegWriteE),
    .ResultSrcE(ResultSrcE),
    .PCSrcE    (PCSrcE),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .mem_req   (mem_req),
    .mem_ready (mem_ready),
    .clr_cnt   (clr_cnt),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushW    (FlushW),
    .mem_err   (mem_err),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_waiting = 0;
  int m_waited  = 0;
  bit m_err     = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  function automatic int exp_fwd(input int rs);
    if (RegWriteM && RdM != 0 && int'(RdM) == rs) return 2;
    if (RegWriteW && RdW != 0 && int'(RdW) == rs) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    int  fa, fb;
    bit  frozen, br, lu, timed_out;
    int  n_stall_f;
    fa = 0; fb = 0; frozen = 0; br = 0; lu = 0; timed_out = 0;
    if (reset) begin
      m_waiting = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      fa = exp_fwd(int'(RS1E));
      fb = exp_fwd(int'(RS2E));
      if (!m_waiting) begin
        if (mem_req && !mem_ready) frozen = 1;
        else if (PCSrcE) br = 1;
        else if (ResultSrcE && RegWriteE && RDE != 0 && (RDE == RS1D || RDE == RS2D)) lu = 1;
      end else if (!mem_ready) begin
        // The access has already stalled m_waited cycles; the one that would reach
        // MEM_TIMEOUT total is handed back to the pipeline instead.
        if (m_waited + 1 >= TIMEOUT) timed_out = 1;
        else frozen = 1;
      end
    end
    check("ForwardAE", ForwardAE, fa);
    check("ForwardBE", ForwardBE, fb);
    check("StallF", StallF, frozen | lu);
    check("StallD", StallD, frozen | lu);
    check("StallE", StallE, frozen);
    check("StallM", StallM, frozen);
    check("FlushD", FlushD, br);
    check("FlushE", FlushE, br | lu);
    check("FlushW", FlushW, frozen);
    check("mem_err", mem_err, m_err);
    check("stall_cnt", stall_cnt, m_stalls);
    check("flush_cnt", flush_cnt, m_flushes);
    if (!reset) begin
      n_stall_f = frozen | lu;
      if (clr_cnt) begin
        m_stalls = 0; m_flushes = 0;
      end else begin
        if (n_stall_f != 0 && m_stalls < CNT_MAX) m_stalls++;
        if (br && m_flushes < CNT_MAX) m_flushes++;
      end
      if (timed_out) m_err = 1;
      m_waiting = frozen;
      m_waited  = frozen ? m_waited + 1 : 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    RS1D = 0; RS2D = 0; RS1E = 0; RS2E = 0; RDE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    mem_req = 0; mem_ready = 0; clr_cnt = 0;
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    at_neg();
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_mem_err", mem_err, 0);
    tick();
    reset = 1'b0;

    // Forwarding priority and register-0 exclusion
    RegWriteM = 1; RdM = 7; RS1E = 7; RegWriteW = 1; RdW = 7;
    at_neg();
    check("fwdA_M", ForwardAE, 2);
    tick();
    RdM = 0;
    at_neg();
    check("fwdA_W", ForwardAE, 1);
    tick();
    RdW = 0; RS2E = 9;
    at_neg();
    check("fwdA_RF", ForwardAE, 0);
    tick();
    RdW = 9;
    at_neg();
    check("fwdB_W", ForwardBE, 1);
    tick();
    quiet();

    // Load-use: one bubble cycle
    ResultSrcE = 1; RegWriteE = 1; RDE = 3; RS2D = 3;
    at_neg();
    check("lu_StallF", StallF, 1);
    check("lu_FlushE", FlushE, 1);
    tick();
    quiet();
    at_neg();
    check("lu_release", StallF, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    tick();

    // Branch overrides load-use
    ResultSrcE = 1; RegWriteE = 1; RDE = 3; RS2D = 3; PCSrcE = 1;
    at_neg();
    check("br_FlushD", FlushD, 1);
    check("br_StallF", StallF, 0);
    tick();
    quiet();
    at_neg();
    check("br_flush_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 1);
    tick();

    // Memory wait: 4 not-ready cycles, then ready
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("mw_StallM", StallM, 1);
      tick();
    end
    mem_ready = 1;
    at_neg();
    check("mw_ready_release", StallF, 0);
    tick();
    quiet();
    at_neg();
    check("mw_stall_cnt", stall_cnt, 5);
    tick();

    // Watchdog: never ready
    mem_req = 1;
    repeat (7) tick();
    at_neg();
    check("wd_release", StallF, 0);
    check("wd_err_pending", mem_err, 0);
    tick();
    quiet();
    at_neg();
    check("wd_mem_err", mem_err, 1);
    check("wd_stall_cnt", stall_cnt, 12);
    tick();
    mem_req = 1; mem_ready = 1;
    tick();
    quiet();
    at_neg();
    check("wd_sticky", mem_err, 1);
    tick();

    // Reset in the middle of a wait
    mem_req = 1;
    repeat (2) tick();
    reset = 1'b1;
    at_neg();
    check("rst_StallF", StallF, 0);
    tick();
    quiet();
    reset = 1'b0;
    at_neg();
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_mem_err", mem_err, 0);
    tick();

    // Saturation then clear
    ResultSrcE = 1; RegWriteE = 1; RDE = 3; RS1D = 3;
    repeat (CNT_MAX + 4) tick();
    quiet();
    at_neg();
    check("sat_stall_cnt", stall_cnt, CNT_MAX);
    tick();
    clr_cnt = 1;
    tick();
    clr_cnt = 0;
    at_neg();
    check("clr_stall_cnt", stall_cnt, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
